// File: rtl/lcd_msg_arbiter_pkg.sv
// Shared definitions for the parking LCD message arbiter: display codes,
// field widths and the arbiter FSM state type.
package lcd_pkg;

  localparam int CODE_W = 4;
  localparam int ID_W   = 28;

  // Display codes understood by the LCD message formatter.
  localparam logic [CODE_W-1:0] LCD_PARK    = 4'd0;
  localparam logic [CODE_W-1:0] LCD_GRANTED = 4'd1;
  localparam logic [CODE_W-1:0] LCD_DENIED  = 4'd2;
  localparam logic [CODE_W-1:0] LCD_EXIT    = 4'd3;
  localparam logic [CODE_W-1:0] LCD_ADMIN   = 4'd4;
  localparam logic [CODE_W-1:0] LCD_OFF     = 4'd15;

  // OFF: power down screen, IDLE: prompt shown, HOLD: a granted message is shown.
  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_IDLE = 2'd1,
    ST_HOLD = 2'd2
  } lcd_state_e;

endpackage

// File: rtl/lcd_msg_arbiter_if.sv
// Requester <-> arbiter bundle for the shared parking LCD.
//
// Handshake: iREQ[i] is a level "valid" that requester i holds high, with
// its code/ID on iREQ_CODE/iREQ_ID, until the arbiter answers with a
// one-cycle oGNT[i] pulse (the "ready"/accept). The code and ID are taken
// from the cycle before the pulse; the requester drops iREQ[i] afterwards.
// oBUSY/oLCD_State/oID are the registered display outputs.
interface lcd_msg_arbiter_if
  import lcd_pkg::*;
#(
  parameter int NUM_REQ = 3
);

  logic [NUM_REQ-1:0]        iREQ;
  logic [CODE_W*NUM_REQ-1:0] iREQ_CODE;
  logic [ID_W*NUM_REQ-1:0]   iREQ_ID;
  logic [NUM_REQ-1:0]        oGNT;
  logic                      oBUSY;
  logic [CODE_W-1:0]         oLCD_State;
  logic [ID_W-1:0]           oID;

  // Requester side.
  modport master (
    output iREQ, iREQ_CODE, iREQ_ID,
    input  oGNT, oBUSY, oLCD_State, oID
  );

  // Arbiter side.
  modport slave (
    input  iREQ, iREQ_CODE, iREQ_ID,
    output oGNT, oBUSY, oLCD_State, oID
  );

endinterface

// File: rtl/lcd_msg_arbiter_rr_arb.sv
// lcd_rr_arb: purely combinational round-robin pick. Searches the request
// vector starting at the pointer and wrapping, and returns a one-hot winner
// plus a valid flag. Kept generic so the gate logic can reuse it.
module lcd_rr_arb #(
  parameter int NUM_REQ = 3,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic               valid
);

  // First asserted request at or after ptr, wrapping NUM_REQ-1 -> 0.
  always_comb begin
    int idx;
    gnt   = '0;
    valid = 1'b0;
    idx   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (!valid && req[idx]) begin
        gnt[idx] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lcd_msg_arbiter.sv
// lcd_msg_arbiter: shares the two-line parking LCD between the admin
// console (requester 0) and the gates. One message at a time, picked
// round-robin, held on screen for HOLD_CYCLES cycles; the idle prompt is
// shown otherwise and the OFF screen whenever parking power is off.
//
// Optional build macro LCD_ARB_PREEMPT_EN: when defined, an admin request
// during another requester's hold replaces that message immediately.
module lcd_msg_arbiter
  import lcd_pkg::*;
#(
  parameter int                NUM_REQ     = 3,
  parameter int                HOLD_CYCLES = 100000000,
  parameter int                CNT_W       = 27,
  parameter logic [CODE_W-1:0] IDLE_CODE   = 4'd0
) (
  input  logic               iCLK,
  input  logic               iRST_N,
  input  logic               iPOWER_ON,
  lcd_msg_arbiter_if.slave   bus,
  output lcd_state_e         oDBG_STATE
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

  lcd_state_e          state_q;
  logic [PTR_W-1:0]    ptr_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [NUM_REQ-1:0]  gnt_q;
  logic                busy_q;
  logic [CODE_W-1:0]   lcd_q;
  logic [ID_W-1:0]     id_q;

  logic [NUM_REQ-1:0]  win_oh;
  logic                win_valid;
  logic [PTR_W-1:0]    win_idx;
  logic                preempt;
  logic                slot_open;
  logic                do_grant;
  logic [PTR_W-1:0]    grant_idx;
  logic [PTR_W-1:0]    grant_ptr;
  logic [NUM_REQ-1:0]  grant_oh;
  logic [CODE_W-1:0]   grant_code;
  logic [ID_W-1:0]     grant_id;

  lcd_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_arb (
    .req   (bus.iREQ),
    .ptr   (ptr_q),
    .gnt   (win_oh),
    .valid (win_valid)
  );

  // One-hot winner to index.
  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_oh[i]) win_idx = PTR_W'(i);
    end
  end

`ifdef LCD_ARB_PREEMPT_EN
  // Current message owner, only needed to decide whether the admin may cut in.
  logic [PTR_W-1:0] owner_q;
  assign preempt = (state_q == ST_HOLD) && bus.iREQ[0] && (owner_q != '0);
`else
  assign preempt = 1'b0;
`endif

  // A new message may start from IDLE or on the last cycle of a hold;
  // admin preemption overrides the round-robin pick and the hold timer.
  assign slot_open  = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && (cnt_q == '0));
  assign do_grant   = preempt || (slot_open && win_valid);
  assign grant_idx  = preempt ? '0 : win_idx;
  assign grant_oh   = NUM_REQ'(1) << grant_idx;
  assign grant_code = bus.iREQ_CODE[int'(grant_idx)*CODE_W +: CODE_W];
  assign grant_id   = bus.iREQ_ID[int'(grant_idx)*ID_W +: ID_W];
  assign grant_ptr  = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);

  // Arbiter FSM with registered display outputs; power loss wins over any grant.
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      state_q <= ST_OFF;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      lcd_q   <= LCD_OFF;
      id_q    <= '0;
`ifdef LCD_ARB_PREEMPT_EN
      owner_q <= '0;
`endif
    end else if (!iPOWER_ON) begin
      state_q <= ST_OFF;
      cnt_q   <= '0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      lcd_q   <= LCD_OFF;
      id_q    <= '0;
    end else begin
      case (state_q)
        ST_OFF: begin
          state_q <= ST_IDLE;
          gnt_q   <= '0;
          busy_q  <= 1'b0;
          lcd_q   <= IDLE_CODE;
          id_q    <= '0;
        end
        ST_IDLE, ST_HOLD: begin
          if (do_grant) begin
            state_q <= ST_HOLD;
            gnt_q   <= grant_oh;
            busy_q  <= 1'b1;
            lcd_q   <= grant_code;
            id_q    <= grant_id;
            cnt_q   <= CNT_LOAD;
            ptr_q   <= grant_ptr;
`ifdef LCD_ARB_PREEMPT_EN
            owner_q <= grant_idx;
`endif
          end else if ((state_q == ST_HOLD) && (cnt_q != '0)) begin
            gnt_q <= '0;
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            lcd_q   <= IDLE_CODE;
            id_q    <= '0;
          end
        end
        default: begin
          state_q <= ST_OFF;
          gnt_q   <= '0;
          busy_q  <= 1'b0;
          lcd_q   <= LCD_OFF;
          id_q    <= '0;
        end
      endcase
    end
  end

  assign bus.oGNT       = gnt_q;
  assign bus.oBUSY      = busy_q;
  assign bus.oLCD_State = lcd_q;
  assign bus.oID        = id_q;
  assign oDBG_STATE     = state_q;

endmodule

// File: tb/tb_lcd_msg_arbiter.sv
// Bench for lcd_msg_arbiter with HOLD_CYCLES=8, NUM_REQ=3. A cycle-level
// model of the display rules (remaining visible cycles, pointer, owner)
// predicts every output; directed scenarios pin literal values, then a
// randomized phase exercises requests, power loss and reset.
module tb_lcd_msg_arbiter;
  import lcd_pkg::*;

  localparam int NR   = 3;
  localparam int HOLD = 8;
  localparam int RW   = NR + CODE_W + ID_W;

  // ---------------- clock / reset ----------------
  logic iCLK = 1'b0;
  logic rst_n;
  logic pwr;
  always #5 iCLK = ~iCLK;

  lcd_msg_arbiter_if #(.NUM_REQ(NR)) bus ();
  lcd_state_e dbg_state;

  lcd_msg_arbiter #(
    .NUM_REQ     (NR),
    .HOLD_CYCLES (HOLD),
    .CNT_W       (4),
    .IDLE_CODE   (4'd0)
  ) dut (
    .iCLK       (iCLK),
    .iRST_N     (rst_n),
    .iPOWER_ON  (pwr),
    .bus        (bus),
    .oDBG_STATE (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [RW-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // m_mode: 0 = power-down screen, 1 = prompt, 2 = message shown.
  // m_left: visible cycles still to go for the current message, counting this one.
  bit             m_valid = 1'b0;
  int             m_mode, m_left, m_ptr, m_owner;
  logic [NR-1:0]  e_gnt;
  logic           e_busy;
  logic [3:0]     e_lcd;
  logic [27:0]    e_id;

  always @(posedge iCLK) begin : model
    int w;
    w = -1;
    if (!rst_n) begin
      m_valid = 1'b1;
      m_mode = 0; m_left = 0; m_ptr = 0; m_owner = 0;
      e_lcd = 4'd15; e_id = '0; e_gnt = '0; e_busy = 1'b0;
      exp_q.delete();
    end else if (!m_valid) begin
      w = -1;
    end else if (!pwr) begin
      m_mode = 0; m_left = 0;
      e_lcd = 4'd15; e_id = '0; e_gnt = '0; e_busy = 1'b0;
    end else if (m_mode == 0) begin
      m_mode = 1;
      e_lcd = 4'd0; e_id = '0; e_gnt = '0; e_busy = 1'b0;
    end else begin
`ifdef LCD_ARB_PREEMPT_EN
      if (m_mode == 2 && bus.iREQ[0] && m_owner != 0) w = 0;
`endif
      if (w < 0 && (m_mode == 1 || m_left == 1)) begin
        for (int k = 0; k < NR; k++)
          if (w < 0 && bus.iREQ[(m_ptr + k) % NR]) w = (m_ptr + k) % NR;
      end
      if (w >= 0) begin
        e_gnt  = '0;
        e_gnt[w] = 1'b1;
        e_lcd  = bus.iREQ_CODE[4*w +: 4];
        e_id   = bus.iREQ_ID[28*w +: 28];
        e_busy = 1'b1;
        m_mode = 2; m_left = HOLD; m_owner = w; m_ptr = (w + 1) % NR;
        exp_q.push_back({e_gnt, e_lcd, e_id});
      end else begin
        e_gnt = '0;
        if (m_mode == 2) begin
          if (m_left == 1) begin
            m_mode = 1; e_lcd = 4'd0; e_id = '0; e_busy = 1'b0;
          end else begin
            m_left--;
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge iCLK) begin : compare
    logic [RW-1:0] rec;
    if (m_valid) begin
      check("cyc_lcd", bus.oLCD_State, e_lcd);
      check("cyc_id", bus.oID, e_id);
      check("cyc_gnt", bus.oGNT, e_gnt);
      check("cyc_busy", bus.oBUSY, e_busy);
      if (bus.oGNT !== '0) begin
        if (exp_q.size() == 0) begin
          total_cnt++;
          $display("FAIL grant_record: got gnt %b with no grant expected (t=%0t)", bus.oGNT, $time);
        end else begin
          rec = exp_q.pop_front();
          check("grant_record", {bus.oGNT, bus.oLCD_State, bus.oID}, rec);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  bit sticky = 1'b0;

  // Advance one cycle; requesters drop their request once granted.
  task automatic step();
    @(negedge iCLK);
    if (!sticky)
      for (int i = 0; i < NR; i++)
        if (bus.oGNT[i] === 1'b1) bus.iREQ[i] = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [3:0] code, input logic [27:0] id);
    bus.iREQ_CODE[4*i +: 4] = code;
    bus.iREQ_ID[28*i +: 28] = id;
    bus.iREQ[i] = 1'b1;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (bus.oBUSY !== 1'b0 && k < 40) begin
      step();
      k++;
    end
    check("wait_idle", bus.oBUSY, 1'b0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_lcd"}, bus.oLCD_State, 4'd15);
    check({tag, "_id"}, bus.oID, 28'd0);
    check({tag, "_gnt"}, bus.oGNT, 3'b000);
    check({tag, "_busy"}, bus.oBUSY, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  int g_idx[4];
  int g_cyc[4];
  int ng, idle_gap, n, pulses, k;

  initial begin
    rst_n = 1'b0; pwr = 1'b0;
    bus.iREQ = '0; bus.iREQ_CODE = '0; bus.iREQ_ID = '0;
    step(); step();

    // 1: reset with power off, then power on
    check_reset_vals("rst");
    rst_n = 1'b1;
    step();
    check("off_stays_off", bus.oLCD_State, 4'd15);
    pwr = 1'b1;
    step();
    check("pwr_on_idle", bus.oLCD_State, 4'd0);

    // 2: single request, grant latency and hold length
    set_req(1, 4'd1, 28'h1234567);
    step();
    check("t2_gnt", bus.oGNT, 3'b010);
    check("t2_lcd", bus.oLCD_State, 4'd1);
    check("t2_id", bus.oID, 28'h1234567);
    check("t2_busy", bus.oBUSY, 1'b1);
    n = 1; pulses = 1;
    for (int c = 0; c < 20 && bus.oBUSY === 1'b1; c++) begin
      step();
      if (bus.oBUSY === 1'b1) n++;
      if (bus.oGNT !== '0) pulses++;
    end
    check("t2_hold_len", n, HOLD);
    check("t2_one_pulse", pulses, 1);
    check("t2_back_idle", bus.oLCD_State, 4'd0);

    // 3: all requesting, back-to-back round robin from pointer 0
    rst_n = 1'b0; step(); rst_n = 1'b1; step();
    sticky = 1'b1;
    set_req(0, 4'd4, 28'h0000001);
    set_req(1, 4'd1, 28'h0000002);
    set_req(2, 4'd3, 28'h0000003);
    ng = 0; idle_gap = 0;
    for (int i = 0; i < 4; i++) begin g_idx[i] = -1; g_cyc[i] = 0; end
    for (int c = 0; c < 60 && ng < 4; c++) begin
      step();
      if (bus.oGNT !== '0) begin
        for (int b = 0; b < NR; b++) if (bus.oGNT[b]) g_idx[ng] = b;
        g_cyc[ng] = c;
        ng++;
      end else if (ng > 0 && bus.oBUSY !== 1'b1) begin
        idle_gap++;
      end
    end
    check("t3_num_grants", ng, 4);
    check("t3_order0", g_idx[0], 0);
    check("t3_order1", g_idx[1], 1);
    check("t3_order2", g_idx[2], 2);
    check("t3_order3", g_idx[3], 0);
    for (int i = 0; i < 3; i++) check("t3_spacing", g_cyc[i+1] - g_cyc[i], HOLD);
    check("t3_no_idle_gap", idle_gap, 0);
    sticky = 1'b0;
    bus.iREQ = '0;
    wait_idle();

    // 4: power loss at hold cycle 3, restore with requester 2 pending
    set_req(1, 4'd2, 28'h0000042);
    step();
    check("t4_gnt", bus.oGNT, 3'b010);
    step(); step();
    pwr = 1'b0;
    set_req(2, 4'd3, 28'h7654321);
    step();
    check("t4_off_lcd", bus.oLCD_State, 4'd15);
    check("t4_off_busy", bus.oBUSY, 1'b0);
    check("t4_off_gnt", bus.oGNT, 3'b000);
    pwr = 1'b1;
    step();
    check("t4_idle_lcd", bus.oLCD_State, 4'd0);
    check("t4_idle_gnt", bus.oGNT, 3'b000);
    step();
    check("t4_gnt2", bus.oGNT, 3'b100);
    check("t4_lcd2", bus.oLCD_State, 4'd3);
    check("t4_id2", bus.oID, 28'h7654321);
    wait_idle();

    // 5: admin request during requester 1's hold
    set_req(1, 4'd1, 28'h0000111);
    step();
    check("t5_gnt1", bus.oGNT, 3'b010);
    step();
    set_req(0, 4'd4, 28'h0000999);
    step();
`ifdef LCD_ARB_PREEMPT_EN
    check("t5_preempt_gnt", bus.oGNT, 3'b001);
    check("t5_preempt_lcd", bus.oLCD_State, 4'd4);
    check("t5_preempt_id", bus.oID, 28'h0000999);
`else
    check("t5_wait_gnt", bus.oGNT, 3'b000);
    check("t5_wait_lcd", bus.oLCD_State, 4'd1);
    k = 1;
    while (bus.oGNT[0] !== 1'b1 && k < 20) begin
      step();
      k++;
    end
    check("t5_admin_latency", k, 7);
    check("t5_admin_lcd", bus.oLCD_State, 4'd4);
`endif
    wait_idle();

    // 6: reset mid-hold clears outputs and pointer
    set_req(2, 4'd3, 28'h0000005);
    step();
    check("t6_gnt", bus.oGNT, 3'b100);
    step();
    rst_n = 1'b0;
    step();
    check_reset_vals("t6_rst");
    rst_n = 1'b1;
    set_req(1, 4'd1, 28'h0000006);
    set_req(2, 4'd2, 28'h0000007);
    step();
    check("t6_idle", bus.oLCD_State, 4'd0);
    step();
    check("t6_ptr0_gnt", bus.oGNT, 3'b010);
    wait_idle();

    // Randomized phase
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 499) != 0);
      if (pwr && $urandom_range(0, 199) == 0) pwr = 1'b0;
      else if (!pwr && $urandom_range(0, 7) == 0) pwr = 1'b1;
      for (int i = 0; i < NR; i++) begin
        bus.iREQ_CODE[4*i +: 4] = 4'($urandom);
        bus.iREQ_ID[28*i +: 28] = 28'($urandom);
        if (!bus.iREQ[i] && $urandom_range(0, 5) == 0) bus.iREQ[i] = 1'b1;
      end
      step();
    end
    rst_n = 1'b1; pwr = 1'b1;
    bus.iREQ = '0;
    for (int c = 0; c < 3; c++) step();
    wait_idle();
    check("exp_q_empty", exp_q.size(), 0);

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
